// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO management master: frame codes, field
// positions, FSM states and the frame-class decode helpers.
package mdio_pkg;

   localparam logic [1:0] ST_C22 = 2'b01;
   localparam logic [1:0] ST_C45 = 2'b00;

   localparam logic [1:0] OP_C22_WR     = 2'b01;
   localparam logic [1:0] OP_C22_RD     = 2'b10;
   localparam logic [1:0] OP_C45_ADDR   = 2'b00;
   localparam logic [1:0] OP_C45_WR     = 2'b01;
   localparam logic [1:0] OP_C45_RD_INC = 2'b10;
   localparam logic [1:0] OP_C45_RD     = 2'b11;

   localparam int ST_LSB = 30;
   localparam int OP_LSB = 28;

   localparam int HDR_BITS  = 14;
   localparam int TA_BITS   = 2;
   localparam int DATA_BITS = 16;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DATA,
      DONE
   } mdio_state_t;

   function automatic logic is_read(input logic [1:0] st, input logic [1:0] op);
      return ((st == ST_C22) && (op == OP_C22_RD)) ||
             ((st == ST_C45) && ((op == OP_C45_RD) || (op == OP_C45_RD_INC)));
   endfunction

   function automatic logic is_valid(input logic [1:0] st, input logic [1:0] op);
      if (st == ST_C22)
         return (op == OP_C22_WR) || (op == OP_C22_RD);
      if (st == ST_C45)
         return (op == OP_C45_ADDR) || (op == OP_C45_WR) ||
                (op == OP_C45_RD_INC) || (op == OP_C45_RD);
      return 1'b0;
   endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC generator: a DIV_HALF-cycle half-period divider with strobes that flag
// the cycle just before MDC rises or falls, so the FSM can act on that edge.
module mdio_mdc_gen
   import mdio_pkg::*;
#(
   parameter int DIV_HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic mdc,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int DIV_W = $clog2(DIV_HALF + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             half_end;

   assign half_end = en && (div_cnt == DIV_LAST);
   assign rise_stb = half_end && !mdc;
   assign fall_stb = half_end && mdc;

   // Disabling holds MDC low with the divider cleared, so every frame starts
   // with a full-length low phase.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div_cnt <= '0;
         mdc     <= 1'b0;
      end else if (half_end) begin
         div_cnt <= '0;
         mdc     <= ~mdc;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22/45 MDIO master: serialises one frame word per start,
// optionally preceded by a preamble, and captures read data from the PHY.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int DIV_HALF = 2,
   parameter int PRE_LEN  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdio_start,
   input  logic [31:0] t_data,
   input  logic        mdio_in,
   output logic [15:0] rd_data,
   output logic        data_rdy,
   output logic        err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_oe,
   output logic        mdio_out
);

   localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
   localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
   localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
   localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);
   localparam mdio_state_t FIRST_STATE = (PRE_LEN == 0) ? HDR : PRE;

   mdio_state_t state, next_state;
   logic [5:0]  bit_cnt;
   logic [31:0] tx_shift;
   logic [31:0] frame_src;
   logic [15:0] rx_shift;
   logic        rd_frame;
   logic        rd_next;
   logic        err_flag;
   logic        reject;
   logic        can_accept;
   logic        start_ok;
   logic        accept;
   logic        reject_now;
   logic        load_bit;
   logic        bit_oe;
   logic        bit_out;
   logic        fall_stb;
   logic        rise_stb;

   mdio_mdc_gen #(
      .DIV_HALF (DIV_HALF)
   ) u_mdc_gen (
      .clk      (clk),
      .reset    (reset),
      .en       (busy),
      .mdc      (mdc),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   // A new request is taken in DONE as well as IDLE so frames can run back to back.
   assign can_accept = (state == IDLE) || (state == DONE);
   assign start_ok   = is_valid(t_data[ST_LSB +: 2], t_data[OP_LSB +: 2]);
   assign accept     = can_accept && mdio_start && start_ok;
   assign reject_now = can_accept && mdio_start && !start_ok;
   assign frame_src  = accept ? t_data : tx_shift;
   assign rd_next    = accept ? is_read(t_data[ST_LSB +: 2], t_data[OP_LSB +: 2]) : rd_frame;
   assign load_bit   = accept ||
                       (fall_stb && (next_state inside {PRE, HDR, TA, DATA}));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Each serial phase ends on the MDC falling edge of its last bit.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: next_state = accept ? FIRST_STATE : IDLE;
         PRE:  if (fall_stb && (bit_cnt == PRE_LAST))  next_state = HDR;
         HDR:  if (fall_stb && (bit_cnt == HDR_LAST))  next_state = TA;
         TA:   if (fall_stb && (bit_cnt == TA_LAST))   next_state = DATA;
         DATA: if (fall_stb && (bit_cnt == DATA_LAST)) next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      data_rdy = 1'b0;
      err      = reject;
      case (state)
         PRE, HDR, TA, DATA: busy = 1'b1;
         DONE: begin
            data_rdy = 1'b1;
            err      = reject | err_flag;
         end
         default: ;
      endcase

      if (next_state == PRE) begin
         bit_oe  = 1'b1;
         bit_out = 1'b1;
      end else begin
         bit_oe  = !(rd_next && ((next_state == TA) || (next_state == DATA)));
         bit_out = bit_oe & frame_src[31];
      end
   end

   // Serial datapath: pins update only on the edge that starts a bit, read
   // data is sampled on the edge where MDC rises.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rd_frame <= 1'b0;
         err_flag <= 1'b0;
         reject   <= 1'b0;
         rd_data  <= '0;
         mdio_oe  <= 1'b0;
         mdio_out <= 1'b0;
      end else begin
         reject <= reject_now;

         if (next_state != state)
            bit_cnt <= '0;
         else if (fall_stb)
            bit_cnt <= bit_cnt + 6'd1;

         if (accept) begin
            rd_frame <= rd_next;
            err_flag <= 1'b0;
         end else if (rise_stb && (state == TA) && (bit_cnt == TA_LAST) &&
                      rd_frame && mdio_in) begin
            err_flag <= 1'b1;
         end

         if (rise_stb && (state == DATA))
            rx_shift <= {rx_shift[14:0], mdio_in};

         if ((state == DATA) && (next_state == DONE) && rd_frame)
            rd_data <= rx_shift;

         if (load_bit && (next_state != PRE))
            tx_shift <= {frame_src[30:0], 1'b0};
         else if (accept)
            tx_shift <= t_data;

         if (load_bit) begin
            mdio_oe  <= bit_oe;
            mdio_out <= bit_out;
         end else if ((next_state == IDLE) || (next_state == DONE)) begin
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b0;
         end
      end
   end

endmodule
